// File: rtl/row_buffer_writer_if.sv
// Pixel stream handshake between a raster source and the row buffer writer.
// master = pixel source, slave = row_buffer_writer.
interface row_buffer_writer_if #(
  parameter int PIX_WIDTH = 8
) ();
  logic                 pix_valid;
  logic                 pix_ready;
  logic [PIX_WIDTH-1:0] pix_data;
  logic                 pix_sof;

  modport master (output pix_valid, output pix_data, output pix_sof, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input pix_sof, output pix_ready);
endinterface

// File: rtl/row_buffer_writer.sv
// Packs a raster pixel stream into words and writes rows round-robin into the row BRAMs.
// Optional RBW_STALL_CNT_EN adds a saturating stall_cnt output (cycles stalled with data waiting).
module row_buffer_writer #(
  parameter int PIX_WIDTH         = 8,
  parameter int PIX_PER_WORD      = 4,
  parameter int BRAM_W_DATA_WIDTH = 32,
  parameter int IMG_WIDTH         = 512,
  parameter int BRAMs             = 4,
  parameter int BRAM_ADDR         = 2,
  parameter int BRAM_DEPTH_ADDR   = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  row_buffer_writer_if.slave           pix,
  input  logic                         row_release,
  output logic                         EN_A,
  output logic [BRAM_ADDR-1:0]         BRAM_W,
  output logic [BRAM_DEPTH_ADDR-1:0]   ADDR_A,
  output logic [BRAM_W_DATA_WIDTH-1:0] DIN_A,
  output logic                         row_done,
  output logic [BRAM_ADDR:0]           rows_filled,
  output logic                         release_err
`ifdef RBW_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int WORDS_PER_ROW = IMG_WIDTH / PIX_PER_WORD;
  localparam int LANE_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [BRAM_DEPTH_ADDR-1:0] LAST_ADDR = BRAM_DEPTH_ADDR'(WORDS_PER_ROW - 1);
  localparam logic [BRAM_ADDR-1:0]       LAST_BRAM = BRAM_ADDR'(BRAMs - 1);
  localparam logic [BRAM_ADDR:0]         FULL_ROWS = (BRAM_ADDR + 1)'(BRAMs);
  localparam logic [LANE_W-1:0]          LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

  if (IMG_WIDTH % PIX_PER_WORD != 0) begin : g_err_img_width
    $error("IMG_WIDTH must be a multiple of PIX_PER_WORD");
  end
  if (PIX_WIDTH * PIX_PER_WORD != BRAM_W_DATA_WIDTH) begin : g_err_word_width
    $error("PIX_WIDTH*PIX_PER_WORD must equal BRAM_W_DATA_WIDTH");
  end
  if (PIX_PER_WORD < 2) begin : g_err_ppw
    $error("PIX_PER_WORD must be at least 2");
  end
  if ((1 << BRAM_ADDR) < BRAMs) begin : g_err_bram_addr
    $error("BRAM_ADDR too narrow for BRAMs");
  end
  if ((1 << BRAM_DEPTH_ADDR) < WORDS_PER_ROW) begin : g_err_depth_addr
    $error("BRAM_DEPTH_ADDR too narrow for one row");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic                         pix_ready_reg;
  logic [LANE_W-1:0]            lane_reg;
  logic [BRAM_DEPTH_ADDR-1:0]   wr_addr_reg;
  logic [BRAM_ADDR-1:0]         wr_bram_reg;
  logic                         en_a_reg;
  logic [BRAM_ADDR-1:0]         bram_w_reg;
  logic [BRAM_DEPTH_ADDR-1:0]   addr_a_reg;
  logic [BRAM_W_DATA_WIDTH-1:0] din_a_reg;
  logic                         row_done_reg;
  logic [BRAM_ADDR:0]           rows_filled_reg, rows_filled_next;
  logic                         release_err_reg, release_err_next;

  logic accept, sof_accept, pix_take, word_issue, row_end;
  logic [BRAM_W_DATA_WIDTH-1:0] word_full;

  always_comb begin
    accept     = pix.pix_valid && pix_ready_reg;
    sof_accept = accept && pix.pix_sof;
    pix_take   = accept && !pix.pix_sof && (state_reg == FILL);
    word_issue = pix_take && (lane_reg == LAST_LANE);
    row_end    = word_issue && (wr_addr_reg == LAST_ADDR);
  end

  // Lanes 0..N-2 are buffered; the top lane comes straight from the completing pixel.
  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_WORD - 1; gi++) begin : g_lane
      logic [PIX_WIDTH-1:0] data_reg;
      logic                 load;

      assign load = (sof_accept && (gi == 0)) || (pix_take && (lane_reg == LANE_W'(gi)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (load) begin
          data_reg <= pix.pix_data;
        end
      end

      assign word_full[gi*PIX_WIDTH +: PIX_WIDTH] = data_reg;
    end
  endgenerate

  assign word_full[(PIX_PER_WORD-1)*PIX_WIDTH +: PIX_WIDTH] = pix.pix_data;

  // A completed row is counted in its row_done cycle, so a release in that
  // same cycle cancels it out.
  always_comb begin
    rows_filled_next = rows_filled_reg;
    release_err_next = release_err_reg;
    if (row_release && !row_done_reg && (rows_filled_reg == '0)) begin
      release_err_next = 1'b1;
    end
    if (sof_accept) begin
      rows_filled_next = '0;
    end else if (row_done_reg && !row_release) begin
      rows_filled_next = rows_filled_reg + 1'b1;
    end else if (!row_done_reg && row_release && (rows_filled_reg != '0)) begin
      rows_filled_next = rows_filled_reg - 1'b1;
    end
  end

  // The row just finished is still pending in rows_filled_next, hence the -1.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (sof_accept) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (row_end && (rows_filled_next >= FULL_ROWS - 1'b1)) begin
          state_next = STALL;
        end
      end
      STALL: begin
        if ((rows_filled_reg < FULL_ROWS) && !row_done_reg) begin
          state_next = FILL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pix_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pix_ready_reg <= (state_next != STALL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg        <= '0;
      wr_addr_reg     <= '0;
      wr_bram_reg     <= '0;
      en_a_reg        <= 1'b0;
      bram_w_reg      <= '0;
      addr_a_reg      <= '0;
      din_a_reg       <= '0;
      row_done_reg    <= 1'b0;
      rows_filled_reg <= '0;
      release_err_reg <= 1'b0;
    end else begin
      en_a_reg        <= word_issue;
      row_done_reg    <= row_end;
      rows_filled_reg <= rows_filled_next;
      release_err_reg <= release_err_next;
      if (sof_accept) begin
        // Frame restart: the partial word is dropped and the sof pixel sits in lane 0.
        lane_reg    <= LANE_W'(1);
        wr_addr_reg <= '0;
        wr_bram_reg <= '0;
        addr_a_reg  <= '0;
        bram_w_reg  <= '0;
      end else if (pix_take) begin
        if (word_issue) begin
          lane_reg   <= '0;
          addr_a_reg <= wr_addr_reg;
          bram_w_reg <= wr_bram_reg;
          din_a_reg  <= word_full;
          if (row_end) begin
            wr_addr_reg <= '0;
            wr_bram_reg <= (wr_bram_reg == LAST_BRAM) ? '0 : wr_bram_reg + 1'b1;
          end else begin
            wr_addr_reg <= wr_addr_reg + 1'b1;
          end
        end else begin
          lane_reg <= lane_reg + 1'b1;
        end
      end
    end
  end

`ifdef RBW_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (sof_accept) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == STALL) && pix.pix_valid && !pix_ready_reg
                 && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  // Stall counter not built.
`endif

  assign pix.pix_ready = pix_ready_reg;
  assign EN_A          = en_a_reg;
  assign BRAM_W        = bram_w_reg;
  assign ADDR_A        = addr_a_reg;
  assign DIN_A         = din_a_reg;
  assign row_done      = row_done_reg;
  assign rows_filled   = rows_filled_reg;
  assign release_err   = release_err_reg;

endmodule

// File: tb/tb_row_buffer_writer.sv
// Directed bench for row_buffer_writer with a pixel-level reference model and per-cycle compare.
module tb_row_buffer_writer;
  localparam int PW    = 8;
  localparam int PPW   = 4;
  localparam int DW    = 32;
  localparam int IMG_W = 16;
  localparam int NB    = 4;
  localparam int BA    = 2;
  localparam int DA    = 7;
  localparam int WPR   = IMG_W / PPW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          row_release = 1'b0;
  logic          EN_A;
  logic [BA-1:0] BRAM_W;
  logic [DA-1:0] ADDR_A;
  logic [DW-1:0] DIN_A;
  logic          row_done;
  logic [BA:0]   rows_filled;
  logic          release_err;
`ifdef RBW_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  row_buffer_writer_if #(.PIX_WIDTH(PW)) pix_if ();

  row_buffer_writer #(
    .PIX_WIDTH(PW), .PIX_PER_WORD(PPW), .BRAM_W_DATA_WIDTH(DW), .IMG_WIDTH(IMG_W),
    .BRAMs(NB), .BRAM_ADDR(BA), .BRAM_DEPTH_ADDR(DA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix(pix_if), .row_release(row_release),
    .EN_A(EN_A), .BRAM_W(BRAM_W), .ADDR_A(ADDR_A), .DIN_A(DIN_A),
    .row_done(row_done), .rows_filled(rows_filled), .release_err(release_err)
`ifdef RBW_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          bram;
    int          addr;
    logic [31:0] data;
    bit          done;
  } wr_t;

  wr_t        exp_q[$];
  int         m_n;
  bit         m_in_frame;
  logic [7:0] m_pix[PPW];
  int         m_rows;
  bit         m_pend;
  bit         m_err;

  always @(posedge clk or negedge rst_n) begin : model
    bit   acc;
    bit   pend_before;
    int   w;
    wr_t  e;
    if (!rst_n) begin
      m_n = 0; m_in_frame = 0; m_rows = 0; m_pend = 0; m_err = 0;
      exp_q.delete();
    end else begin
      acc         = pix_if.pix_valid && pix_if.pix_ready;
      pend_before = m_pend;
      m_pend      = 0;
      if (row_release && !pend_before && m_rows == 0) m_err = 1;
      if (acc && pix_if.pix_sof) begin
        m_in_frame = 1;
        m_pix[0]   = pix_if.pix_data;
        m_n        = 1;
        m_rows     = 0;
      end else begin
        if (pend_before && !row_release) m_rows++;
        else if (!pend_before && row_release && m_rows > 0) m_rows--;
        if (acc && m_in_frame) begin
          m_pix[m_n % PPW] = pix_if.pix_data;
          if (m_n % PPW == PPW - 1) begin
            w      = m_n / PPW;
            e.bram = (w / WPR) % NB;
            e.addr = w % WPR;
            for (int k = 0; k < PPW; k++) e.data[k*8 +: 8] = m_pix[k];
            e.done = (e.addr == WPR - 1);
            exp_q.push_back(e);
            m_pend = e.done;
          end
          m_n++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int prev_eff = NB;

  always @(negedge clk) begin : compare
    wr_t e;
    int  eff;
    if (!rst_n) begin
      prev_eff = NB;
    end else if (chk_en) begin
      if (EN_A) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: actual BRAM_W=%0d ADDR_A=%0d required no write", BRAM_W, ADDR_A);
        end else begin
          e = exp_q.pop_front();
          check("wr_bram", 64'(BRAM_W), 64'(e.bram));
          check("wr_addr", 64'(ADDR_A), 64'(e.addr));
          check("wr_data", 64'(DIN_A), 64'(e.data));
          check("wr_row_done", 64'(row_done), 64'(e.done));
        end
      end else begin
        check("row_done_without_write", 64'(row_done), 64'(0));
      end
      check("rows_filled", 64'(rows_filled), 64'(m_rows));
      check("release_err", 64'(release_err), 64'(m_err));
      // Full buffer forces ready low; ready must be back once below full for a whole cycle.
      eff = m_rows + int'(m_pend);
      if (eff >= NB) check("ready_when_full", 64'(pix_if.pix_ready), 64'(0));
      else if (prev_eff < NB) check("ready_when_room", 64'(pix_if.pix_ready), 64'(1));
      prev_eff = eff;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input logic s);
    int t;
    t = 0;
    pix_if.pix_valid = 1'b1;
    pix_if.pix_data  = d;
    pix_if.pix_sof   = s;
    while (!pix_if.pix_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL send_timeout: actual pix_ready=0 for %0d cycles, required 1", t);
    end else begin
      @(negedge clk);
    end
    pix_if.pix_valid = 1'b0;
    pix_if.pix_sof   = 1'b0;
  endtask

  task automatic send_run(input int first, input int count);
    for (int i = 0; i < count; i++) send(8'(first + i), 1'b0);
  endtask

  task automatic pulse_release();
    row_release = 1'b1;
    @(negedge clk);
    row_release = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_if.pix_valid = 1'b0;
    pix_if.pix_data  = '0;
    pix_if.pix_sof   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(pix_if.pix_ready), 64'(0));
    check("reset_en_a", 64'(EN_A), 64'(0));
    check("reset_din", 64'(DIN_A), 64'(0));
    check("reset_addr", 64'(ADDR_A), 64'(0));
    check("reset_bram", 64'(BRAM_W), 64'(0));
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // First word of a frame.
    send(8'h01, 1'b1);
    send_run(8'h02, 3);
    check("first_en_a", 64'(EN_A), 64'(1));
    check("first_din", 64'(DIN_A), 64'h04030201);
    check("first_bram", 64'(BRAM_W), 64'(0));
    check("first_addr", 64'(ADDR_A), 64'(0));

    // Rest of row 0.
    send_run(8'h05, 12);
    check("row0_done", 64'(row_done), 64'(1));
    check("row0_last_addr", 64'(ADDR_A), 64'(3));
    @(negedge clk);
    check("row0_rows_filled", 64'(rows_filled), 64'(1));

    // Row 1 starts in BRAM 1.
    send_run(8'h11, 4);
    check("row1_din", 64'(DIN_A), 64'h14131211);
    check("row1_bram", 64'(BRAM_W), 64'(1));
    check("row1_addr", 64'(ADDR_A), 64'(0));
    send_run(8'h15, 12);

    // Rows 2 and 3 fill every BRAM.
    send_run(8'h21, 32);
    check("full_ready", 64'(pix_if.pix_ready), 64'(0));
    @(negedge clk);
    check("full_rows", 64'(rows_filled), 64'(4));

    // Offer data while full.
    pix_if.pix_valid = 1'b1;
    pix_if.pix_data  = 8'hEE;
    repeat (10) @(negedge clk);
    pix_if.pix_valid = 1'b0;
    check("stalled_rows", 64'(rows_filled), 64'(4));
`ifdef RBW_STALL_CNT_EN
    check("stall_cnt_10", 64'(stall_cnt), 64'(10));
`endif

    // One release frees a row; ready returns one cycle after the count drops.
    pulse_release();
    check("release_rows", 64'(rows_filled), 64'(3));
    check("release_ready_lag", 64'(pix_if.pix_ready), 64'(0));
    @(negedge clk);
    check("release_ready", 64'(pix_if.pix_ready), 64'(1));
    send_run(8'h41, 4);
    check("wrap_bram", 64'(BRAM_W), 64'(0));
    check("wrap_addr", 64'(ADDR_A), 64'(0));
    check("wrap_din", 64'(DIN_A), 64'h44434241);

    // Two more pixels then a new frame: the partial word is dropped.
    send_run(8'h45, 2);
    send(8'h80, 1'b1);
    check("sof_rows", 64'(rows_filled), 64'(0));
    check("sof_no_write", 64'(EN_A), 64'(0));
`ifdef RBW_STALL_CNT_EN
    check("stall_cnt_sof", 64'(stall_cnt), 64'(0));
`endif
    send_run(8'h81, 3);
    check("sof_din", 64'(DIN_A), 64'h83828180);
    check("sof_bram", 64'(BRAM_W), 64'(0));
    check("sof_addr", 64'(ADDR_A), 64'(0));

    // Finish rows 0,1 of the new frame, then release during row 2's row_done.
    send_run(8'h84, 28);
    @(negedge clk);
    check("frame2_rows", 64'(rows_filled), 64'(2));
    send_run(8'hA0, 16);
    check("coincide_row_done", 64'(row_done), 64'(1));
    pulse_release();
    check("coincide_rows", 64'(rows_filled), 64'(2));
    @(negedge clk);
    check("coincide_rows_after", 64'(rows_filled), 64'(2));

    // Drain to zero, then one release too many.
    pulse_release();
    @(negedge clk);
    pulse_release();
    @(negedge clk);
    check("drained_rows", 64'(rows_filled), 64'(0));
    check("no_err_yet", 64'(release_err), 64'(0));
    pulse_release();
    check("release_err_set", 64'(release_err), 64'(1));
    repeat (2) @(negedge clk);
    check("release_err_sticky", 64'(release_err), 64'(1));

    // Asynchronous reset while a write is on the port.
    send(8'h55, 1'b1);
    send_run(8'h56, 3);
    check("pre_reset_en_a", 64'(EN_A), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_en_a", 64'(EN_A), 64'(0));
    check("async_err", 64'(release_err), 64'(0));
    check("async_ready", 64'(pix_if.pix_ready), 64'(0));
    check("async_din", 64'(DIN_A), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h21, 1'b1);
    send_run(8'h22, 3);
    check("post_reset_din", 64'(DIN_A), 64'h24232221);
    check("post_reset_bram", 64'(BRAM_W), 64'(0));

    repeat (3) @(negedge clk);
    check("writes_drained", 64'(exp_q.size()), 64'(0));
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
